seq_player: RTL

//  Downstream consumer of mod: builds a Simon-style pattern from successive index values,

---
 rtl/seq_player.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seq_player.sv
// seq_player: Simon-style pattern game.
// Each round appends one index to a pattern memory, plays the whole pattern
// on a one-hot 8-LED display, then checks the player's presses against it.
// A wrong press ends the game; completing MAX_LEN rounds wins it.
module seq_player #(
   parameter int MAX_LEN     = 16,
   parameter int SHOW_CYCLES = 4,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] index,
   input  logic       btn_valid,
   input  logic [2:0] btn_idx,
   output logic [7:0] led,
   output logic [4:0] round,
   output logic       busy,
   output logic       win,
   output logic       lose
);

   // Pattern address width; a one-entry pattern still needs a 1-bit pointer.
   localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   // Timer must hold the larger of the two phase lengths.
   localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
   localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPEND,
      S_SHOW_ON,
      S_SHOW_OFF,
      S_INPUT,
      S_WIN,
      S_LOSE
   } state_t;

   state_t          state_reg, state_next;
   logic [4:0]      len_reg, len_next;
   logic [AW-1:0]   ptr_reg, ptr_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic [7:0]      led_reg, led_next;
   logic            busy_reg, busy_next;
   logic            win_reg, win_next;
   logic            lose_reg, lose_next;

   // Pattern storage; contents are only meaningful below len_reg.
   logic [2:0]      mem [MAX_LEN];
   logic            mem_we;
   logic            last_step;
   logic [2:0]      cur_val;
   logic [2:0]      show_val;

   assign mem_we    = (state_reg == S_APPEND);
   assign last_step = (5'(ptr_reg) == (len_reg - 5'd1));
   assign cur_val   = mem[ptr_reg];

   // Append the new pattern entry at the end of the current pattern.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[len_reg[AW-1:0]] <= index;
      end
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         len_reg   <= '0;
         ptr_reg   <= '0;
         timer_reg <= '0;
         led_reg   <= '0;
         busy_reg  <= 1'b0;
         win_reg   <= 1'b0;
         lose_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         len_reg   <= len_next;
         ptr_reg   <= ptr_next;
         timer_reg <= timer_next;
         led_reg   <= led_next;
         busy_reg  <= busy_next;
         win_reg   <= win_next;
         lose_reg  <= lose_next;
      end
   end

   // Next-state logic plus look-ahead decode of the registered outputs.
   always_comb begin
      state_next = state_reg;
      len_next   = len_reg;
      ptr_next   = ptr_reg;
      timer_next = timer_reg;
      show_val   = '0;

      case (state_reg)
         S_IDLE, S_WIN, S_LOSE: begin
            if (start) begin
               len_next   = '0;
               state_next = S_APPEND;
            end
         end

         S_APPEND: begin
            len_next   = len_reg + 5'd1;
            ptr_next   = '0;
            timer_next = '0;
            state_next = S_SHOW_ON;
         end

         S_SHOW_ON: begin
            if (timer_reg == SHOW_LAST) begin
               timer_next = '0;
               state_next = S_SHOW_OFF;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end

         S_SHOW_OFF: begin
            if (timer_reg == GAP_LAST) begin
               timer_next = '0;
               if (last_step) begin
                  ptr_next   = '0;
                  state_next = S_INPUT;
               end else begin
                  ptr_next   = ptr_reg + AW'(1);
                  state_next = S_SHOW_ON;
               end
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end

         S_INPUT: begin
            if (btn_valid) begin
               if (btn_idx != cur_val) begin
                  state_next = S_LOSE;
               end else if (!last_step) begin
                  ptr_next = ptr_reg + AW'(1);
               end else if (len_reg == LEN_MAX) begin
                  state_next = S_WIN;
               end else begin
                  state_next = S_APPEND;
               end
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase

      // The entry about to be shown may be the one being written this very
      // cycle (first round), so forward the incoming index in that case.
      if (mem_we && (ptr_next == len_reg[AW-1:0])) begin
         show_val = index;
      end else begin
         show_val = mem[ptr_next];
      end

      led_next  = (state_next == S_SHOW_ON) ? (8'd1 << show_val) : 8'd0;
      busy_next = (state_next == S_APPEND) || (state_next == S_SHOW_ON) ||
                  (state_next == S_SHOW_OFF);
      win_next  = (state_next == S_WIN);
      lose_next = (state_next == S_LOSE);
   end

   assign led   = led_reg;
   assign round = len_reg;
   assign busy  = busy_reg;
   assign win   = win_reg;
   assign lose  = lose_reg;

endmodule
